// File: rtl/fb_pkg.sv
// Shared frame-buffer constants, colour codes and slot types for the 640x480
// 3-bit colour-code display path.
package fb_pkg;

    localparam int unsigned FB_W     = 640;
    localparam int unsigned FB_H     = 480;
    localparam int unsigned FB_DEPTH = FB_W * FB_H;
    localparam int unsigned FB_LAST  = FB_DEPTH - 1;
    localparam int unsigned ADDR_W   = 19;
    localparam int unsigned PIX_W    = 3;

    typedef enum logic [PIX_W-1:0] {
        WHITE  = 3'd0,
        BLACK  = 3'd1,
        RED    = 3'd2,
        BLUE   = 3'd3,
        GREEN  = 3'd4,
        YELLOW = 3'd5
    } colour_e;

    typedef enum logic [1:0] {
        SLOT_IDLE,
        SLOT_READ,
        SLOT_WRITE
    } slot_e;

    // Raster successor: wraps from the last visible pixel back to 0.
    function automatic logic [ADDR_W-1:0] next_scan(input logic [ADDR_W-1:0] addr);
        return (addr == ADDR_W'(FB_LAST)) ? '0 : addr + 1'b1;
    endfunction

endpackage

// File: rtl/fb_scan_addr.sv
// Raster scan address counter: advances once per read slot, restarts at 0 on
// frame_start and wraps after the last visible pixel.
module fb_scan_addr
    import fb_pkg::*;
(
    input  logic              CLK,
    input  logic              RST,
    input  logic              advance,
    input  logic              clear,
    output logic [ADDR_W-1:0] rd_addr
);

    logic [ADDR_W-1:0] scan_addr_q;
    logic [ADDR_W-1:0] scan_addr_d;

    // A read coinciding with frame_start must already use address 0.
    always_comb begin
        rd_addr     = clear ? '0 : scan_addr_q;
        scan_addr_d = advance ? next_scan(rd_addr) : rd_addr;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            scan_addr_q <= '0;
        end else begin
            scan_addr_q <= scan_addr_d;
        end
    end

endmodule

// File: rtl/fb_arbiter.sv
// Single-port frame-buffer arbiter: display scan-out reads win their slot, the
// draw engine's req/ack writes fill the rest. Optional macro: FB_WR_CHECK_EN.
module fb_arbiter
    import fb_pkg::*;
(
    input  logic              CLK,
    input  logic              RST,
    input  logic              pix_ce,
    input  logic              scan_en,
    input  logic              frame_start,
    output logic [PIX_W-1:0]  disp_pix,
    output logic              disp_vld,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [PIX_W-1:0]  wr_data,
    output logic              wr_ack,
    output logic              wr_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [PIX_W-1:0]  mem_din,
    input  logic [PIX_W-1:0]  mem_dout
);

    slot_e             slot;
    logic [ADDR_W-1:0] rd_addr;
    logic              wr_ok;

    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_we_q,   mem_we_d;
    logic [PIX_W-1:0]  mem_din_q,  mem_din_d;
    logic              wr_ack_q,   wr_ack_d;
    logic              rd_p1_q,    rd_p1_d;
    logic              rd_p2_q,    rd_p2_d;
    logic              disp_vld_q, disp_vld_d;
    logic [PIX_W-1:0]  disp_pix_q, disp_pix_d;

    // Writes are refused while wr_ack is high so a slow-dropping wr_req cannot double-write.
    always_comb begin
        slot = SLOT_IDLE;
        if (pix_ce && scan_en) begin
            slot = SLOT_READ;
        end else if (wr_req && !wr_ack_q) begin
            slot = SLOT_WRITE;
        end
    end

    fb_scan_addr u_scan (
        .CLK     (CLK),
        .RST     (RST),
        .advance (slot == SLOT_READ),
        .clear   (frame_start),
        .rd_addr (rd_addr)
    );

`ifdef FB_WR_CHECK_EN
    logic wr_err_q, wr_err_d;

    assign wr_ok = (wr_addr <= ADDR_W'(FB_LAST));

    always_comb begin
        wr_err_d = wr_err_q | ((slot == SLOT_WRITE) && !wr_ok);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_err_q <= 1'b0;
        end else begin
            wr_err_q <= wr_err_d;
        end
    end

    assign wr_err = wr_err_q;
`else
    assign wr_ok  = 1'b1;
    assign wr_err = 1'b0;
`endif

    // NOTE: every output of this block gets a default first, so no latch can be inferred.
    always_comb begin
        mem_addr_d = mem_addr_q;
        mem_we_d   = 1'b0;
        mem_din_d  = mem_din_q;
        wr_ack_d   = 1'b0;
        rd_p1_d    = 1'b0;
        unique case (slot)
            SLOT_READ: begin
                mem_addr_d = rd_addr;
                rd_p1_d    = 1'b1;
            end
            SLOT_WRITE: begin
                mem_addr_d = wr_addr;
                mem_din_d  = wr_data;
                mem_we_d   = wr_ok;
                wr_ack_d   = 1'b1;
            end
            default: ;
        endcase
        // rd_p1: address at the BRAM; rd_p2: mem_dout valid; then register for display.
        rd_p2_d    = rd_p1_q;
        disp_vld_d = rd_p2_q;
        disp_pix_d = rd_p2_q ? mem_dout : disp_pix_q;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            mem_addr_q <= '0;
            mem_we_q   <= 1'b0;
            mem_din_q  <= '0;
            wr_ack_q   <= 1'b0;
            rd_p1_q    <= 1'b0;
            rd_p2_q    <= 1'b0;
            disp_vld_q <= 1'b0;
            disp_pix_q <= '0;
        end else begin
            mem_addr_q <= mem_addr_d;
            mem_we_q   <= mem_we_d;
            mem_din_q  <= mem_din_d;
            wr_ack_q   <= wr_ack_d;
            rd_p1_q    <= rd_p1_d;
            rd_p2_q    <= rd_p2_d;
            disp_vld_q <= disp_vld_d;
            disp_pix_q <= disp_pix_d;
        end
    end

    assign mem_addr = mem_addr_q;
    assign mem_we   = mem_we_q;
    assign mem_din  = mem_din_q;
    assign wr_ack   = wr_ack_q;
    assign disp_vld = disp_vld_q;
    assign disp_pix = disp_pix_q;

endmodule

// File: tb/tb_fb_arbiter.sv
// Self-checking bench for fb_arbiter: BRAM model plus a transaction-level
// reference (queue of pending display reads, shadow frame buffer).
`timescale 1ns/1ps
module tb_fb_arbiter;
    import fb_pkg::*;

`ifdef FB_WR_CHECK_EN
    localparam bit RANGE_CHK = 1'b1;
`else
    localparam bit RANGE_CHK = 1'b0;
`endif

    logic              CLK = 1'b0;
    logic              RST = 1'b1;
    logic              pix_ce = 1'b0;
    logic              scan_en = 1'b0;
    logic              frame_start = 1'b0;
    logic              wr_req = 1'b0;
    logic [ADDR_W-1:0] wr_addr = '0;
    logic [PIX_W-1:0]  wr_data = '0;
    logic [PIX_W-1:0]  disp_pix;
    logic              disp_vld;
    logic              wr_ack;
    logic              wr_err;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [PIX_W-1:0]  mem_din;
    logic [PIX_W-1:0]  mem_dout = '0;

    fb_arbiter dut (
        .CLK         (CLK),
        .RST         (RST),
        .pix_ce      (pix_ce),
        .scan_en     (scan_en),
        .frame_start (frame_start),
        .disp_pix    (disp_pix),
        .disp_vld    (disp_vld),
        .wr_req      (wr_req),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_ack      (wr_ack),
        .wr_err      (wr_err),
        .mem_addr    (mem_addr),
        .mem_we      (mem_we),
        .mem_din     (mem_din),
        .mem_dout    (mem_dout)
    );

    always #5 CLK = ~CLK;

    // Single-port BRAM, read-first, one-cycle read latency.
    logic [PIX_W-1:0] bram [FB_DEPTH];
    always @(posedge CLK) begin
        if (mem_we) bram[mem_addr] <= mem_din;
        mem_dout <= (int'(mem_addr) < FB_DEPTH) ? bram[mem_addr] : '0;
    end

    // Reference model state.
    typedef struct {
        int               due;
        logic [PIX_W-1:0] pix;
    } rd_t;

    logic [PIX_W-1:0]  ref_mem [FB_DEPTH];
    rd_t               rdq[$];
    int                cyc = 0;
    int                m_scan = 0;
    logic [ADDR_W-1:0] m_addr = '0;
    logic              m_we = 1'b0, m_ack = 1'b0, m_err = 1'b0, m_vld = 1'b0;
    logic [PIX_W-1:0]  m_din = '0, m_pix = '0;
    int                errors = 0;
    int                checks = 0;

    function automatic logic [28:0] obs_v();
        return {mem_addr, mem_we, mem_din, wr_ack, wr_err, disp_vld, disp_pix};
    endfunction

    function automatic logic [28:0] exp_v();
        return {m_addr, m_we, m_din, m_ack, m_err, m_vld, m_pix};
    endfunction

    // Advance one clock: predict from the inputs presented this cycle, then
    // step past the edge and retire any display read due now.
    task automatic tick();
        bit  rd, wr;
        int  a;
        rd_t e;
        rd = pix_ce && scan_en;
        wr = !rd && wr_req && !m_ack;
        if (RST) begin
            m_scan = 0; m_addr = '0; m_we = 0; m_din = '0;
            m_ack = 0; m_err = 0; m_pix = '0;
            rdq.delete();
        end else begin
            m_we = 0;
            if (rd) begin
                a = frame_start ? 0 : m_scan;
                e.due = cyc + 3;
                e.pix = ref_mem[a];
                rdq.push_back(e);
                m_addr = ADDR_W'(a);
                m_scan = (a + 1) % FB_DEPTH;
            end else if (frame_start) begin
                m_scan = 0;
            end
            if (wr) begin
                m_addr = wr_addr;
                m_din  = wr_data;
                if (!RANGE_CHK || int'(wr_addr) < FB_DEPTH) begin
                    ref_mem[wr_addr] = wr_data;
                    m_we = 1;
                end else begin
                    m_err = 1;
                end
            end
            m_ack = wr;
        end
        @(posedge CLK);
        #1;
        cyc++;
        m_vld = 0;
        if (rdq.size() > 0 && rdq[0].due == cyc) begin
            m_vld = 1;
            m_pix = rdq[0].pix;
            void'(rdq.pop_front());
        end
    endtask

    task automatic test_reset();
        RST = 1; wr_req = 1; wr_addr = 19'd7; wr_data = 3'd3; pix_ce = 1; scan_en = 1;
        repeat (3) tick();
        checks++;
        if (obs_v() !== 29'd0) begin
            errors++;
            $display("FAIL reset_hold got={addr,we,din,ack,err,vld,pix}=%h exp=0", obs_v());
        end
        wr_req = 0; pix_ce = 0; scan_en = 0; RST = 0;
        tick();
        checks++;
        if (obs_v() !== exp_v() || obs_v() !== 29'd0) begin
            errors++;
            $display("FAIL reset_release got=%h exp=0", obs_v());
        end
    endtask

    task automatic test_scan_sequence();
        int seq = 0;
        scan_en = 1;
        for (int i = 0; i < 48; i++) begin
            pix_ce = (i % 4 == 0);
            tick();
            checks++;
            if (obs_v() !== exp_v()) begin
                errors++;
                $display("FAIL scan cyc=%0d got=%h exp=%h", cyc, obs_v(), exp_v());
            end
            if (disp_vld) begin
                checks++;
                if (disp_pix !== PIX_W'(seq % 6)) begin
                    errors++;
                    $display("FAIL scan_pix n=%0d got=%0d exp=%0d", seq, disp_pix, seq % 6);
                end
                seq++;
            end
        end
        pix_ce = 0;
        checks++;
        if (seq !== 12) begin
            errors++;
            $display("FAIL scan_count got=%0d exp=12", seq);
        end
    endtask

    task automatic test_wrap();
        int exp_a[4];
        int k = 0;
        exp_a[0] = FB_LAST - 1; exp_a[1] = FB_LAST; exp_a[2] = 0; exp_a[3] = 1;
        pix_ce = 0; scan_en = 1;
        repeat (4) tick();
        force dut.u_scan.scan_addr_q = ADDR_W'(FB_LAST - 1);
        tick();
        release dut.u_scan.scan_addr_q;
        m_scan = FB_LAST - 1;
        for (int i = 0; i < 16; i++) begin
            pix_ce = (i % 4 == 0);
            tick();
            checks++;
            if (obs_v() !== exp_v()) begin
                errors++;
                $display("FAIL wrap cyc=%0d got=%h exp=%h", cyc, obs_v(), exp_v());
            end
            if (i % 4 == 0) begin
                checks++;
                if (mem_addr !== ADDR_W'(exp_a[k])) begin
                    errors++;
                    $display("FAIL wrap_addr n=%0d got=%0d exp=%0d", k, mem_addr, exp_a[k]);
                end
                k++;
            end
        end
        pix_ce = 0;
    endtask

    task automatic test_write_stream();
        int acks = 0;
        scan_en = 1; wr_req = 1;
        wr_addr = ADDR_W'($urandom_range(63)); wr_data = PIX_W'($urandom_range(5));
        for (int i = 0; i < 80; i++) begin
            pix_ce = (i % 4 == 0);
            tick();
            checks++;
            if (obs_v() !== exp_v()) begin
                errors++;
                $display("FAIL wstream cyc=%0d got=%h exp=%h", cyc, obs_v(), exp_v());
            end
            if (wr_ack) begin
                acks++;
                wr_addr = ADDR_W'($urandom_range(63));
                wr_data = PIX_W'($urandom_range(5));
            end
        end
        wr_req = 0; pix_ce = 0;
        checks++;
        if (acks !== 40) begin
            errors++;
            $display("FAIL wstream_acks got=%0d exp=40", acks);
        end
        // Read back the written region through the display path.
        for (int i = 0; i < 132; i++) begin
            pix_ce = (i % 2 == 0) && (i < 128);
            frame_start = (i == 0);
            tick();
            checks++;
            if (obs_v() !== exp_v()) begin
                errors++;
                $display("FAIL readback cyc=%0d got=%h exp=%h", cyc, obs_v(), exp_v());
            end
        end
        pix_ce = 0; frame_start = 0;
    endtask

    task automatic test_collision();
        int acks = 0;
        scan_en = 1; pix_ce = 1; wr_req = 1; wr_addr = 19'd10; wr_data = RED;
        tick();
        pix_ce = 0;
        checks++;
        if (mem_we !== 1'b0 || wr_ack !== 1'b0 || obs_v() !== exp_v()) begin
            errors++;
            $display("FAIL coll_read got we=%b ack=%b all=%h exp we=0 ack=0 all=%h", mem_we, wr_ack, obs_v(), exp_v());
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            if (wr_ack) begin
                acks++;
                wr_req = 0;
            end
            checks++;
            if (obs_v() !== exp_v()) begin
                errors++;
                $display("FAIL coll cyc=%0d got=%h exp=%h", cyc, obs_v(), exp_v());
            end
            if (i == 0) begin
                checks++;
                if (mem_we !== 1'b1 || mem_addr !== 19'd10 || mem_din !== RED || wr_ack !== 1'b1) begin
                    errors++;
                    $display("FAIL coll_write got we=%b addr=%0d din=%0d ack=%b exp we=1 addr=10 din=2 ack=1", mem_we, mem_addr, mem_din, wr_ack);
                end
            end
        end
        checks++;
        if (acks !== 1) begin
            errors++;
            $display("FAIL coll_acks got=%0d exp=1", acks);
        end
    endtask

    task automatic test_frame_start();
        scan_en = 1;
        frame_start = 1;
        tick();
        frame_start = 0;
        for (int i = 0; i < 10000; i++) begin
            pix_ce = (i % 2 == 0);
            tick();
            checks++;
            if (obs_v() !== exp_v()) begin
                errors++;
                $display("FAIL fs_run cyc=%0d got=%h exp=%h", cyc, obs_v(), exp_v());
            end
        end
        pix_ce = 1; frame_start = 1;
        tick();
        pix_ce = 0; frame_start = 0;
        checks++;
        if (mem_addr !== 19'd0 || obs_v() !== exp_v()) begin
            errors++;
            $display("FAIL fs_first got=%0d exp=0", mem_addr);
        end
        tick();
        pix_ce = 1;
        tick();
        pix_ce = 0;
        checks++;
        if (mem_addr !== 19'd1 || obs_v() !== exp_v()) begin
            errors++;
            $display("FAIL fs_next got=%0d exp=1", mem_addr);
        end
        repeat (4) tick();
    endtask

    task automatic test_reset_pending();
        wr_req = 1; wr_addr = 19'd20; wr_data = BLUE; RST = 1;
        repeat (2) begin
            tick();
            checks++;
            if (wr_ack !== 1'b0 || mem_we !== 1'b0) begin
                errors++;
                $display("FAIL rst_wr got ack=%b we=%b exp ack=0 we=0", wr_ack, mem_we);
            end
        end
        wr_req = 0; RST = 0;
        tick();
        scan_en = 1; pix_ce = 1;
        tick();
        pix_ce = 0; RST = 1;
        tick();
        RST = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (disp_vld !== 1'b0 || obs_v() !== exp_v()) begin
                errors++;
                $display("FAIL rst_rd cyc=%0d got vld=%b all=%h exp vld=0 all=%h", cyc, disp_vld, obs_v(), exp_v());
            end
        end
    endtask

`ifdef FB_WR_CHECK_EN
    task automatic test_range_err();
        pix_ce = 0; wr_req = 1; wr_addr = ADDR_W'(FB_DEPTH); wr_data = GREEN;
        tick();
        wr_req = 0;
        checks++;
        if (wr_ack !== 1'b1 || mem_we !== 1'b0 || wr_err !== 1'b1) begin
            errors++;
            $display("FAIL range got ack=%b we=%b err=%b exp ack=1 we=0 err=1", wr_ack, mem_we, wr_err);
        end
        repeat (5) begin
            tick();
            checks++;
            if (wr_err !== 1'b1 || mem_we !== 1'b0) begin
                errors++;
                $display("FAIL range_sticky got err=%b we=%b exp err=1 we=0", wr_err, mem_we);
            end
        end
        RST = 1;
        tick();
        RST = 0;
        checks++;
        if (wr_err !== 1'b0) begin
            errors++;
            $display("FAIL range_clear got err=%b exp 0", wr_err);
        end
    endtask
`endif

    initial begin
        for (int i = 0; i < FB_DEPTH; i++) begin
            bram[i]    = PIX_W'(i % 6);
            ref_mem[i] = PIX_W'(i % 6);
        end
        test_reset();
        test_scan_sequence();
        test_wrap();
        test_write_stream();
        test_collision();
        test_frame_start();
        test_reset_pending();
`ifdef FB_WR_CHECK_EN
        test_range_err();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
